// File: rtl/melody_player_if.sv
// Control, song-ROM and speaker signals shared between melody_player and its board environment.
interface melody_player_if #(
    parameter int AW    = 5,
    parameter int DIV_W = 16
);
    logic               start;
    logic               stop;
    logic               loop;
    logic [AW-1:0]      rom_addr;
    logic [8+DIV_W-1:0] rom_data;
    logic               speaker;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, loop, rom_data,
        input  rom_addr, speaker, busy, done
    );

    modport slave (
        input  start, stop, loop, rom_data,
        output rom_addr, speaker, busy, done
    );
endinterface

// File: rtl/melody_player.sv
// Plays {dur, div} notes from a synchronous song ROM as a square wave on the speaker pin.
// Optional staccato articulation (silent final tick) is enabled by defining MELODY_GAP_EN.
module melody_player #(
    parameter int CLK_HZ   = 12_000_000,
    parameter int TICK_HZ  = 16,
    parameter int SONG_LEN = 32,
    parameter int DIV_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    melody_player_if.slave bus
);
    localparam int AW       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int TICK_CYC = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic [AW-1:0]     ADDR_LAST = AW'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     rom_addr_q, rom_addr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [7:0]        dur_q, dur_d;
    logic [DIV_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]        dur_cnt_q, dur_cnt_d;
    logic              tone_q, tone_d;
    logic              done_q, done_d;

    logic [7:0]        rom_dur;
    logic [DIV_W-1:0]  rom_div;
    logic              tick_wrap;
    logic              note_end;
    logic              last_entry;
    logic              start_ok;
    logic              gap;

    assign rom_dur    = bus.rom_data[8+DIV_W-1:DIV_W];
    assign rom_div    = bus.rom_data[DIV_W-1:0];
    assign tick_wrap  = (tick_cnt_q == TICK_LAST);
    assign note_end   = tick_wrap && (dur_cnt_q == dur_q - 8'd1);
    assign last_entry = (rom_addr_q == ADDR_LAST);
    // The done cycle is already IDLE, yet a start landing there must still be ignored.
    assign start_ok   = bus.start && !done_q;

`ifdef MELODY_GAP_EN
    assign gap = (state_q == PLAY) && (dur_q >= 8'd2) && (dur_cnt_q == dur_q - 8'd1);
`else
    assign gap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            div_q      <= '0;
            dur_q      <= '0;
            tone_cnt_q <= '0;
            tick_cnt_q <= '0;
            dur_cnt_q  <= '0;
            tone_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            div_q      <= div_d;
            dur_q      <= dur_d;
            tone_cnt_q <= tone_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start_ok) state_d = FETCH;
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (rom_dur == 8'd0) begin
                        state_d = bus.loop ? FETCH : IDLE;
                    end else begin
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (note_end) begin
                        state_d = (last_entry && !bus.loop) ? IDLE : FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        div_d      = div_q;
        dur_d      = dur_q;
        tone_cnt_d = tone_cnt_q;
        tick_cnt_d = tick_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        tone_d     = tone_q;
        done_d     = 1'b0;
        if (bus.stop) begin
            rom_addr_d = '0;
            tone_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) rom_addr_d = '0;
                end
                LOAD: begin
                    div_d      = rom_div;
                    dur_d      = rom_dur;
                    tone_cnt_d = '0;
                    tick_cnt_d = '0;
                    dur_cnt_d  = '0;
                    tone_d     = 1'b0;
                    if (rom_dur == 8'd0) begin
                        rom_addr_d = '0;
                        done_d     = !bus.loop;
                    end
                end
                PLAY: begin
                    // A zero divider is a rest: the tone counter and speaker stay frozen at 0.
                    if (div_q != '0) begin
                        if (tone_cnt_q == div_q - DIV_W'(1)) begin
                            tone_cnt_d = '0;
                            tone_d     = ~tone_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + DIV_W'(1);
                        end
                    end
                    if (tick_wrap) begin
                        tick_cnt_d = '0;
                        dur_cnt_d  = dur_cnt_q + 8'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                    if (note_end) begin
                        tone_d = 1'b0;
                        if (last_entry) begin
                            rom_addr_d = '0;
                            done_d     = !bus.loop;
                        end else begin
                            rom_addr_d = rom_addr_q + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rom_addr = rom_addr_q;
        bus.busy     = (state_q != IDLE);
        bus.done     = done_q;
        bus.speaker  = tone_q && !gap;
    end
endmodule

// File: tb/tb_melody_player.sv
// Self-checking bench for melody_player: per-note arithmetic reference model, random songs, stop/reset cases.
module tb_melody_player;
    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int SONG_LEN = 4;
    localparam int DIV_W    = 16;
    localparam int AW       = 2;
    localparam int T        = CLK_HZ / TICK_HZ;
`ifdef MELODY_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [8+DIV_W-1:0] rom_mem [SONG_LEN];

    bit q_spk  [$];
    bit q_busy [$];
    bit q_done [$];
    int q_addr [$];

    melody_player_if #(.AW(AW), .DIV_W(DIV_W)) bus ();

    melody_player #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .SONG_LEN(SONG_LEN),
        .DIV_W   (DIV_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous song ROM.
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    function automatic logic [8+DIV_W-1:0] ent(input int dur, input int dv);
        return {8'(dur), DIV_W'(dv)};
    endfunction

    task automatic set_rom(input logic [8+DIV_W-1:0] e0, e1, e2, e3);
        rom_mem[0] = e0;
        rom_mem[1] = e1;
        rom_mem[2] = e2;
        rom_mem[3] = e3;
    endtask

    function automatic bit tone_at(input int j, input int dur, input int dv);
        if (dv == 0) return 1'b0;
        if (GAP && dur >= 2 && j >= (dur - 1) * T) return 1'b0;
        return ((j / dv) % 2) == 1;
    endfunction

    task automatic push_exp(input bit s, input bit b, input bit d, input int a);
        q_spk.push_back(s);
        q_busy.push_back(b);
        q_done.push_back(d);
        q_addr.push_back(a);
    endtask

    // Expected per-cycle outputs, cycle 0 being the one right after the start edge.
    // Loop is taken as 1 for end-of-song decisions made in cycles < loop_off.
    task automatic build_expect(input int loop_off, input int max_cyc, input int tail);
        int idx, dur, dv, last;
        bit fin;
        q_spk.delete();
        q_busy.delete();
        q_done.delete();
        q_addr.delete();
        idx = 0;
        fin = 1'b0;
        while (!fin && q_spk.size() < max_cyc) begin
            dur = int'(rom_mem[idx][8+DIV_W-1:DIV_W]);
            dv  = int'(rom_mem[idx][DIV_W-1:0]);
            push_exp(1'b0, 1'b1, 1'b0, idx);
            push_exp(1'b0, 1'b1, 1'b0, idx);
            if (dur == 0) begin
                last = q_spk.size() - 1;
                if (last < loop_off) idx = 0;
                else fin = 1'b1;
            end else begin
                for (int j = 0; j < dur * T; j++) push_exp(tone_at(j, dur, dv), 1'b1, 1'b0, idx);
                last = q_spk.size() - 1;
                if (idx == SONG_LEN - 1) begin
                    if (last < loop_off) idx = 0;
                    else fin = 1'b1;
                end else begin
                    idx++;
                end
            end
        end
        if (fin) begin
            push_exp(1'b0, 1'b0, 1'b1, -1);
            for (int k = 0; k < tail; k++) push_exp(1'b0, 1'b0, 1'b0, -1);
        end else begin
            while (q_spk.size() > max_cyc) begin
                void'(q_spk.pop_back());
                void'(q_busy.pop_back());
                void'(q_done.pop_back());
                void'(q_addr.pop_back());
            end
        end
    endtask

    // Called at a negedge; pulses start so that the next edge samples it.
    task automatic start_song();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Checks cycles 0..n-1 at each negedge, optionally pulsing start while busy or in the done cycle.
    task automatic run_check(input string tag, input int n, input int loop_off, input int pulse_pct);
        for (int c = 0; c < n; c++) begin
            n_checks++;
            if (bus.speaker !== q_spk[c]) begin
                n_fail++;
                $display("[TB] FAIL %s speaker c=%0d got %b exp %b", tag, c, bus.speaker, q_spk[c]);
            end
            n_checks++;
            if (bus.busy !== q_busy[c]) begin
                n_fail++;
                $display("[TB] FAIL %s busy c=%0d got %b exp %b", tag, c, bus.busy, q_busy[c]);
            end
            n_checks++;
            if (bus.done !== q_done[c]) begin
                n_fail++;
                $display("[TB] FAIL %s done c=%0d got %b exp %b", tag, c, bus.done, q_done[c]);
            end
            if (q_addr[c] >= 0) begin
                n_checks++;
                if (bus.rom_addr !== AW'(q_addr[c])) begin
                    n_fail++;
                    $display("[TB] FAIL %s rom_addr c=%0d got %0d exp %0d", tag, c, bus.rom_addr, q_addr[c]);
                end
            end
            bus.loop  = (c < loop_off);
            bus.start = (pulse_pct > 0) &&
                        (q_done[c] || (q_busy[c] && ($urandom_range(0, 99) < pulse_pct)));
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.speaker !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== '0) begin
            n_fail++;
            $display("[TB] FAIL %s idle got busy=%b spk=%b done=%b addr=%0d exp 0 0 0 0",
                     tag, bus.busy, bus.speaker, bus.done, bus.rom_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.loop  = 1'b0;
        set_rom(ent(0, 0), ent(0, 0), ent(0, 0), ent(0, 0));
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic test_single_note();
        set_rom(ent(2, 5), ent(0, 0), ent(1, 1), ent(1, 1));
        build_expect(0, 1000, 2);
        start_song();
        run_check("single_note", q_spk.size(), 0, 30);
    endtask

    task automatic test_rest();
        set_rom(ent(3, 0), ent(1, 4), ent(0, 0), ent(2, 2));
        build_expect(0, 1000, 2);
        start_song();
        run_check("rest", q_spk.size(), 0, 0);
    endtask

    task automatic test_loop();
        set_rom(ent(1, 2), ent(1, 3), ent(1, 4), ent(1, 1));
        build_expect(100, 1000, 2);
        start_song();
        run_check("loop", q_spk.size(), 100, 20);
    endtask

    task automatic test_stop();
        set_rom(ent(3, 4), ent(2, 1), ent(0, 0), ent(0, 0));
        build_expect(0, 1000, 0);
        start_song();
        run_check("stop_pre", 15, 0, 0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check_idle("stop_mid_note");
        @(negedge clk);
        check_idle("stop_settled");
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_idle("start_stop_same");
        @(negedge clk);
        check_idle("start_stop_settled");
    endtask

    task automatic test_back_to_back();
        set_rom(ent(1, 2), ent(0, 0), ent(0, 0), ent(0, 0));
        build_expect(0, 1000, 0);
        start_song();
        run_check("b2b_first", q_spk.size(), 0, 0);
        build_expect(0, 1000, 2);
        start_song();
        run_check("b2b_second", q_spk.size(), 0, 0);
    endtask

    task automatic test_reset_async();
        set_rom(ent(1, 3), ent(2, 2), ent(0, 0), ent(0, 0));
        build_expect(0, 1000, 0);
        start_song();
        run_check("rst_pre", 17, 0, 0);
        n_checks++;
        if (bus.speaker !== q_spk[17] || bus.rom_addr !== AW'(q_addr[17])) begin
            n_fail++;
            $display("[TB] FAIL rst_pre_state got spk=%b addr=%0d exp spk=%b addr=%0d",
                     bus.speaker, bus.rom_addr, q_spk[17], q_addr[17]);
        end
        #1 rst = 1'b1;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_release");
    endtask

    task automatic test_gap();
        set_rom(ent(2, 3), ent(0, 0), ent(0, 0), ent(0, 0));
        build_expect(0, 1000, 2);
        start_song();
        run_check("gap", q_spk.size(), 0, 0);
    endtask

    task automatic test_random();
        int loop_off;
        for (int it = 0; it < 8; it++) begin
            rom_mem[0] = ent($urandom_range(1, 3), $urandom_range(0, 6));
            for (int i = 1; i < SONG_LEN; i++) rom_mem[i] = ent($urandom_range(0, 3), $urandom_range(0, 6));
            loop_off = $urandom_range(0, 150);
            build_expect(loop_off, 300, 1);
            start_song();
            run_check("random", q_spk.size(), loop_off, 10);
            bus.stop = 1'b1;
            @(negedge clk);
            bus.stop = 1'b0;
            check_idle("random_stop");
        end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_rest();
        test_loop();
        test_stop();
        test_back_to_back();
        test_reset_async();
`ifdef MELODY_GAP_EN
        test_gap();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/melody_player.md
# melody_player

Parametrised successor to the fixed-song musical box. It plays a note sequence that it reads from an external synchronous song ROM and drives a square-wave `speaker` output. Pitch, duration, rests, looping and start/stop control are all run-time or parameter driven. It sits between the board's song memory (iCE40 BRAM or a LUT ROM) and the speaker pin, and uses the single 12 MHz system clock.

## Interface
Parameters:
- `CLK_HZ`, 12_000_000: system clock frequency.
- `TICK_HZ`, 16: duration tick rate. `TICK_CYC = CLK_HZ/TICK_HZ` cycles per tick; must be ≥2.
- `SONG_LEN`, 32: number of ROM entries, ≥1. `AW = $clog2(SONG_LEN)`, minimum 1.
- `DIV_W`, 16: width of the pitch divider field.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  one-cycle request to play from entry 0; ignored while `busy`.
- `stop`  in  1  abort; wins over `start` when both arrive in the same cycle.
- `loop`  in  1  level signal, sampled at end of song; 1 = restart at entry 0.
- `rom_addr`  out  AW  registered song ROM address.
- `rom_data`  in  8+DIV_W  `{dur[7:0], div[DIV_W-1:0]}`; valid one cycle after `rom_addr` (synchronous ROM).
- `speaker`  out  1  square-wave tone output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on natural song end with `loop`=0.

## Operation
- Note encoding:
  - `dur` = length in ticks; `dur`=0 is the end-of-song marker.
  - `div` = half-period in clock cycles; `div`=0 is a rest, with `speaker` held at 0.
  - Tone frequency = `CLK_HZ/(2*div)`.
- States:
  - IDLE: on `start` (and no `stop`), set `rom_addr`←0 and go to FETCH.
  - FETCH: one cycle of ROM latency, then go to LOAD.
  - LOAD: latch `div`/`dur`. If `dur`==0, take the end-of-song action. Otherwise clear the tone, tick and duration counters, set `speaker`←0 and go to PLAY.
  - PLAY:
    - Tone counter counts 0..`div`-1; at `div`-1 it wraps and `speaker` toggles.
    - Tick counter counts 0..`TICK_CYC`-1; at wrap the duration counter increments.
    - When the duration counter reaches `dur`: set `speaker`←0. If `rom_addr`==`SONG_LEN`-1, take the end-of-song action; else `rom_addr`+1 and go to FETCH.
- End-of-song action:
  - `loop`=1: `rom_addr`←0, go to FETCH, no `done`.
  - `loop`=0: go to IDLE, pulse `done`.
- `stop` in any state: next state is IDLE, `speaker`←0, `rom_addr`←0, no `done`.
- `start` while `busy` is ignored, including in the cycle `done` is asserted.
- `div` changes between notes take effect only at LOAD. There is no phase carry-over: each note starts with `speaker`=0.
- Reset values: state IDLE, `speaker`=0, `busy`=0, `done`=0, `rom_addr`=0, all counters 0. Reset asserted mid-note silences the output immediately (asynchronous).

## Timing
- `start` sampled at edge k:
  - `rom_addr`=0 after edge k.
  - LOAD after edge k+1.
  - PLAY after edge k+2.
  - First `speaker` rise after edge k+2+`div`.
- A note occupies exactly `dur*TICK_CYC` cycles in PLAY.
- Inter-note overhead is 2 cycles (FETCH + LOAD) with `speaker`=0.
- `done` is asserted for the single cycle following the LOAD (or the PLAY end) that triggers the end-of-song action.
- `busy` rises after edge k and falls in the same cycle `done` rises.

## Configuration
- `MELODY_GAP_EN`:
  - Defined: for notes with `dur`≥2, `speaker` is forced to 0 during the final tick (staccato articulation). Tone counter keeps running; total note length is unchanged.
  - Undefined: legato, and the tone sounds for all `dur` ticks.

## Test plan
All scenarios use `CLK_HZ`=1000, `TICK_HZ`=100 (`TICK_CYC`=10), `SONG_LEN`=4 and a behavioural sync ROM.
- ROM {dur=2,div=5}, {dur=0}; `start` pulse → `speaker` toggles every 5 cycles for 20 PLAY cycles, then `done` is high for 1 cycle and `busy` falls.
- Entry with `div`=0, `dur`=3 → `speaker` stays 0 for 30 cycles, then the next note plays.
- 4 notes without a marker, `loop`=1 → `rom_addr` sequence 0,1,2,3,0,…, `done` never asserted; then set `loop`=0 → `done` pulses after entry 3.
- `stop` mid-note, plus `start`+`stop` in the same cycle → IDLE next cycle, `speaker`=0, no `done`; `start` while `busy` has no effect.
- `rst` asserted mid-PLAY between clock edges → `speaker`, `busy` and `rom_addr` go to 0 immediately.
- With `MELODY_GAP_EN`, {dur=2,div=3} → `speaker` is 0 for the last 10 cycles of the note; total note length is still 20 cycles.
